// File: rtl/event_encoder8to3.sv
// Rising-edge event encoder: latches edges on 8 request lines and serves them one at a time as a 3-bit code with a valid/ack handshake.
// Build option: define ENC_ROUND_ROBIN_EN for round-robin selection; fixed priority (bit 0 first) otherwise.

module event_encoder8to3_lane (
  input  logic clock,
  input  logic reset,
  input  logic en,
  input  logic req,
  input  logic clr,
  output logic pend,
  output logic ovf
);
  logic req_q;
  logic set;

  assign set = en & req & ~req_q;
  assign ovf = set & pend;

  // A new edge beats the served-index clear on the same edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      req_q <= 1'b0;
      pend  <= 1'b0;
    end else begin
      req_q <= req;
      if (set)      pend <= 1'b1;
      else if (clr) pend <= 1'b0;
    end
  end
endmodule

module event_encoder8to3 #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         en,
  input  logic [N-1:0] req,
  input  logic         ack,
  output logic [W-1:0] code,
  output logic         valid,
  output logic [N-1:0] pending,
  output logic         overflow
);
  typedef enum logic {IDLE, HOLD} state_t;

  state_t       state;
  logic [N-1:0] clr;
  logic [N-1:0] ovf_hit;
  logic [W-1:0] sel;
  logic         load;

  genvar i;
  for (i = 0; i < N; i++) begin : g_lane
    event_encoder8to3_lane u_lane (
      .clock (clock),
      .reset (reset),
      .en    (en),
      .req   (req[i]),
      .clr   (clr[i]),
      .pend  (pending[i]),
      .ovf   (ovf_hit[i])
    );
  end

`ifdef ENC_ROUND_ROBIN_EN
  logic [W-1:0] last;
  logic [W-1:0] idx;
  logic         found;

  // Scan starts just past the last served line, so that line ranks last.
  always_comb begin
    sel   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      idx = last + W'(k);
      if (!found && pending[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end
`else
  always_comb begin
    sel = '0;
    for (int k = N - 1; k >= 0; k--)
      if (pending[k]) sel = k[W-1:0];
  end
`endif

  // Selection uses pending before this edge's new sets.
  assign load = (|pending) && ((state == IDLE) || ack);

  always_comb begin
    clr = '0;
    if (load) clr[sel] = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      code     <= '0;
      valid    <= 1'b0;
      overflow <= 1'b0;
`ifdef ENC_ROUND_ROBIN_EN
      last     <= W'(N - 1);
`endif
    end else begin
      if (|ovf_hit) overflow <= 1'b1;
      if (load) begin
        code  <= sel;
        valid <= 1'b1;
        state <= HOLD;
`ifdef ENC_ROUND_ROBIN_EN
        last  <= sel;
`endif
      end else if (state == HOLD && ack) begin
        valid <= 1'b0;
        state <= IDLE;
      end
    end
  end
endmodule
